alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the LC-3b combinational ALU.
- Supports the same seven ops (ADD, AND, NOT, XOR, LSHF, RSHFA, RSHFL) at generic WIDTH.
- Adds an iterative shift-add MUL and a carry flag.
- Registers every result and its flags, with valid/ready flow control on input and output, so it can sit between the datapath register file and a pipelined writeback stage.

Parameters:
WIDTH, 16, operand/result width; must be a power of two and at least 4.
SHW, $clog2(WIDTH), shift-amount width; derived localparam, not overridable.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept this cycle
in1  input  WIDTH  operand A (shift source)
in2  input  WIDTH  operand B
op  input  3  0 ADD, 1 AND, 2 NOT(in1), 3 XOR, 4 LSHF, 5 RSHFA, 6 RSHFL, 7 MUL
shift  input  SHW  shift amount for ops 4-6
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result this cycle
out  output  WIDTH  registered result
zero  output  1  out == 0
positive  output  1  out != 0 and MSB == 0
negative  output  1  MSB of out
carry  output  1  ADD carry-out; MUL high half nonzero; 0 otherwise

Behaviour:
- States: IDLE, BUSY (MUL only), DONE (result held).
- Reset (rst_n low at an edge, from any state): state IDLE; out, zero, positive, negative, carry, out_valid = 0; MUL accumulator and counter cleared. in_ready = 1 after the reset edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational from state and out_ready only; never from in_valid.
- Accept = in_valid && in_ready. On accept, op, in1, in2 and shift are latched. Later input changes have no effect on the in-flight op.
- Ops 0-6, on the accept edge:
  - Compute the result and flags; go to DONE.
  - out_valid is high the cycle after the accept cycle (latency 1).
  - ADD is modulo 2^WIDTH; carry = bit WIDTH of the sum.
  - Shifts by shift bits: LSHF zero-fills; RSHFA replicates the MSB; RSHFL zero-fills. shift = 0 passes in1 unchanged.
- Op 7 (MUL):
  - Accept edge: load multiplicand = in1, multiplier = in2, 2*WIDTH accumulator = 0, counter = WIDTH; go to BUSY.
  - Each BUSY edge: if the multiplier LSB is 1, add the multiplicand (shifted by the bit index) into the accumulator; shift the multiplier right; decrement the counter.
  - The edge on which the counter goes 1->0 enters DONE with out = low WIDTH bits and carry = |high WIDTH bits (unsigned product).
  - out_valid is high WIDTH+1 cycles after the accept cycle. in_ready = 0 throughout BUSY; in_valid is ignored there.
- Flags are derived from the final out value only, for every op. Exactly one of zero/positive/negative is 1 when out_valid = 1.
- DONE:
  - out_ready = 0: out, flags and out_valid are held stable; in_ready = 0.
  - out_ready = 1 and no accept: next state IDLE; out_valid = 0; out and flags keep their last value.
  - out_ready = 1 with an accept in the same cycle: the new op is taken (back-to-back). A single-cycle op returns to DONE with the new result, so out_valid stays high; MUL goes to BUSY with out_valid = 0.
- Reset during BUSY aborts the multiply; no partial result is ever presented.
- No combinational path from in1/in2/op to out or flags.

Test Plan:
- WIDTH=16: ADD in1=32783 (0x800F), in2=37 -> out=0x8034, negative=1, carry=0, out_valid exactly 1 cycle after accept.
- RSHFL in1=0x800F, shift=5 -> 0x0400, positive=1. RSHFA same inputs -> 0xFC00, negative=1. LSHF 0x800F by 5 -> 0x01E0.
- MUL 300*250 -> out=0x24F8, carry=1, out_valid 17 cycles after accept, in_ready=0 for all 16 BUSY cycles. MUL 0*0xFFFF -> out=0, zero=1, carry=0.
- Backpressure: complete AND 0xF0F0&0x0FF0=0x00F0, hold out_ready=0 for 5 cycles -> out and flags stable, in_ready=0. Then out_ready=1 with in_valid=1 carrying XOR 0xAAAA^0xFFFF -> 0x5555 presented the next cycle, out_valid never drops.
- Reset mid-MUL: assert rst_n=0 on BUSY cycle 8 -> next cycle out_valid=0, out=0, all flags 0, in_ready=1. Subsequent NOT 0x0000 -> 0xFFFF, negative=1.
- Wrap: ADD 0xFFFF+0x0001 -> out=0, zero=1, carry=1. Rerun ADD and MUL checks with WIDTH=8 (e.g. MUL 20*13=260 -> out=0x04, carry=1, latency 9).

Source files
------------

// File: rtl/alu_seq.sv
//------------------------------------------------------------------------------
// Module   : alu_seq
// Purpose  : Handshaked LC-3b style ALU with iterative shift-add multiply,
//            registered result and zero/positive/negative/carry flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module alu_seq #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             positive,
    output logic             negative,
    output logic             carry
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_AND   = 3'd1;
    localparam logic [2:0] OP_NOT   = 3'd2;
    localparam logic [2:0] OP_XOR   = 3'd3;
    localparam logic [2:0] OP_LSHF  = 3'd4;
    localparam logic [2:0] OP_RSHFA = 3'd5;
    localparam logic [2:0] OP_RSHFL = 3'd6;
    localparam logic [2:0] OP_MUL   = 3'd7;

    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic                 accept;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     mplier;
    logic [SHW:0]         cnt;
    logic                 mul_last;
    logic signed [WIDTH-1:0] in1_s;
    logic [WIDTH:0]       alu_res;
    logic                 load_res;
    logic [WIDTH-1:0]     res_val;
    logic                 res_carry;

    assign accept   = in_valid && in_ready;
    assign mul_last = (cnt == CNT_ONE);
    assign in1_s    = in1;
    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (op == OP_MUL) ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (mul_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_nxt = (op == OP_MUL) ? S_BUSY : S_DONE;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs depend on state and out_ready only
    always_comb begin
        in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
        out_valid = (state == S_DONE);
    end

    // Single-cycle ops; bit WIDTH carries the ADD carry-out
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:   alu_res = {1'b0, in1} + {1'b0, in2};
            OP_AND:   alu_res = {1'b0, in1 & in2};
            OP_NOT:   alu_res = {1'b0, ~in1};
            OP_XOR:   alu_res = {1'b0, in1 ^ in2};
            OP_LSHF:  alu_res = {1'b0, in1 << shift};
            OP_RSHFA: alu_res = {1'b0, in1_s >>> shift};
            OP_RSHFL: alu_res = {1'b0, in1 >> shift};
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        load_res  = (accept && (op != OP_MUL)) || ((state == S_BUSY) && mul_last);
        res_val   = (state == S_BUSY) ? acc_step[WIDTH-1:0] : alu_res[WIDTH-1:0];
        res_carry = (state == S_BUSY) ? (|acc_step[2*WIDTH-1:WIDTH]) : alu_res[WIDTH];
    end

    // Multiplier iteration and result/flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            cnt      <= '0;
            out      <= '0;
            zero     <= 1'b0;
            positive <= 1'b0;
            negative <= 1'b0;
            carry    <= 1'b0;
        end else begin
            if (accept && (op == OP_MUL)) begin
                mcand  <= {{WIDTH{1'b0}}, in1};
                mplier <= in2;
                acc    <= '0;
                cnt    <= CNT_INIT;
            end else if (state == S_BUSY) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CNT_ONE;
            end
            if (load_res) begin
                out      <= res_val;
                zero     <= (res_val == '0);
                positive <= (res_val != '0) && !res_val[WIDTH-1];
                negative <= res_val[WIDTH-1];
                carry    <= res_carry;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_seq
// Purpose  : Scoreboard bench for alu_seq at WIDTH=16 (lane 0) and WIDTH=8 (lane 1).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_alu_seq;

    typedef struct {
        int          lane;
        int          acc;
        int          lat;
        logic [15:0] res;
        logic [3:0]  flg;   // {zero, positive, negative, carry}
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_v  [2];
    logic        out_ready_v [2];
    logic [15:0] in1_v [2];
    logic [15:0] in2_v [2];
    logic [2:0]  op_v  [2];
    logic [3:0]  sh_v  [2];
    logic        rand_rdy;

    logic        ir16, ov16, z16, p16, n16, c16;
    logic [15:0] out16;
    logic        ir8, ov8, z8, p8, n8, c8;
    logic [7:0]  out8;

    logic [15:0] mon_out [2];
    logic [3:0]  mon_flg [2];
    logic        mon_ir  [2];
    logic        mon_ov  [2];

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[0]), .in_ready(ir16),
        .in1(in1_v[0]), .in2(in2_v[0]), .op(op_v[0]), .shift(sh_v[0]),
        .out_valid(ov16), .out_ready(out_ready_v[0]), .out(out16),
        .zero(z16), .positive(p16), .negative(n16), .carry(c16)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[1]), .in_ready(ir8),
        .in1(in1_v[1][7:0]), .in2(in2_v[1][7:0]), .op(op_v[1]), .shift(sh_v[1][2:0]),
        .out_valid(ov8), .out_ready(out_ready_v[1]), .out(out8),
        .zero(z8), .positive(p8), .negative(n8), .carry(c8)
    );

    assign mon_out[0] = out16;
    assign mon_out[1] = {8'h00, out8};
    assign mon_flg[0] = {z16, p16, n16, c16};
    assign mon_flg[1] = {z8, p8, n8, c8};
    assign mon_ir[0]  = ir16;
    assign mon_ir[1]  = ir8;
    assign mon_ov[0]  = ov16;
    assign mon_ov[1]  = ov8;

    // Reference model: plain arithmetic on the unsigned operands
    function automatic exp_t model(int l, logic [2:0] o, logic [15:0] a_i,
                                   logic [15:0] b_i, logic [3:0] s_i);
        exp_t   e;
        int     w;
        int     sh;
        longint mask, a, b, r, p, sa;
        logic   c;
        w    = (l == 0) ? 16 : 8;
        mask = (64'sd1 <<< w) - 1;
        a    = longint'(a_i) & mask;
        b    = longint'(b_i) & mask;
        sh   = int'(s_i) & (w - 1);
        c    = 1'b0;
        r    = 0;
        case (o)
            3'd0: begin p = a + b; r = p & mask; c = ((p >> w) & 1) != 0; end
            3'd1: r = a & b;
            3'd2: r = (~a) & mask;
            3'd3: r = a ^ b;
            3'd4: r = (a << sh) & mask;
            3'd5: begin
                sa = (((a >> (w - 1)) & 1) != 0) ? (a - (64'sd1 <<< w)) : a;
                r  = (sa >>> sh) & mask;
            end
            3'd6: r = a >> sh;
            default: begin p = a * b; r = p & mask; c = (p >> w) != 0; end
        endcase
        e.lane = l;
        e.lat  = (o == 3'd7) ? w + 1 : 1;
        e.acc  = 0;
        e.res  = r[15:0];
        e.flg  = {r == 0, (r != 0) && (((r >> (w - 1)) & 1) == 0),
                  ((r >> (w - 1)) & 1) != 0, c};
        return e;
    endfunction

    task automatic chk(string nm, int l, logic [15:0] act, logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s lane%0d cyc %0d: got %h expected %h", nm, l, cyc, act, exp_v);
        end
    endtask

    // Monitor: derives expected valid/ready from the scoreboard and compares
    initial begin
        int   idx;
        bit   ev, er, rst_seen, just_rst;
        exp_t e;
        rst_seen = 1'b0;
        just_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                for (int l = 0; l < 2; l++) begin
                    idx = -1;
                    foreach (q[i]) if (idx < 0 && q[i].lane == l) idx = i;
                    ev = (idx >= 0) && (cyc >= q[idx].acc + q[idx].lat);
                    er = (idx < 0) || (ev && out_ready_v[l]);
                    if (just_rst) begin
                        chk("reset_out", l, mon_out[l], 16'h0);
                        chk("reset_flags", l, {12'h0, mon_flg[l]}, 16'h0);
                    end
                    chk("out_valid", l, {15'h0, mon_ov[l]}, {15'h0, ev});
                    chk("in_ready", l, {15'h0, mon_ir[l]}, {15'h0, er});
                    if (ev && mon_ov[l] === 1'b1) begin
                        chk("result", l, mon_out[l], q[idx].res);
                        chk("flags", l, {12'h0, mon_flg[l]}, {12'h0, q[idx].flg});
                        if (out_ready_v[l]) q.delete(idx);
                    end
                    if (rst_n && in_valid_v[l] && mon_ir[l] === 1'b1) begin
                        e     = model(l, op_v[l], in1_v[l], in2_v[l], sh_v[l]);
                        e.acc = cyc;
                        q.push_back(e);
                    end
                end
            end
            if (!rst_n) begin
                q.delete();
                rst_seen = 1'b1;
                just_rst = 1'b1;
            end else begin
                just_rst = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            out_ready_v[0] = ($urandom_range(0, 3) != 0);
            out_ready_v[1] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic issue(int l, logic [2:0] o, logic [15:0] a, logic [15:0] b, logic [3:0] s);
        bit done;
        done           = 1'b0;
        in_valid_v[l]  = 1'b1;
        op_v[l]        = o;
        in1_v[l]       = a;
        in2_v[l]       = b;
        sh_v[l]        = s;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = (mon_ir[l] === 1'b1);
            tick();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout lane%0d cyc %0d: got in_ready 0 expected 1", l, cyc);
        end
        in_valid_v[l] = 1'b0;
        op_v[l]       = 3'($urandom);
        in1_v[l]      = 16'($urandom);
        in2_v[l]      = 16'($urandom);
        sh_v[l]       = 4'($urandom);
    endtask

    task automatic drain();
        rand_rdy       = 1'b0;
        out_ready_v[0] = 1'b1;
        out_ready_v[1] = 1'b1;
        for (int t = 0; t < 100 && q.size() != 0; t++) tick();
        tick();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout cyc %0d: got %0d pending expected 0", cyc, q.size());
            q.delete();
        end
    endtask

    task automatic random_ops(int l, int n);
        rand_rdy = 1'b1;
        for (int k = 0; k < n; k++) begin
            issue(l, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 4'($urandom));
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc %0d: got no finish expected finish", cyc);
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        rand_rdy = 1'b0;
        for (int l = 0; l < 2; l++) begin
            in_valid_v[l]  = 1'b0;
            out_ready_v[l] = 1'b1;
            in1_v[l] = '0; in2_v[l] = '0; op_v[l] = '0; sh_v[l] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // WIDTH=16 directed cases
        issue(0, 3'd0, 16'h800F, 16'd37, 4'd0);
        issue(0, 3'd6, 16'h800F, 16'h0, 4'd5);
        issue(0, 3'd5, 16'h800F, 16'h0, 4'd5);
        issue(0, 3'd4, 16'h800F, 16'h0, 4'd5);
        issue(0, 3'd4, 16'h1234, 16'h0, 4'd0);
        issue(0, 3'd7, 16'd300, 16'd250, 4'd0);
        issue(0, 3'd7, 16'h0000, 16'hFFFF, 4'd0);
        issue(0, 3'd0, 16'hFFFF, 16'h0001, 4'd0);
        drain();

        // Backpressure, then back-to-back accept while presenting
        out_ready_v[0] = 1'b0;
        issue(0, 3'd1, 16'hF0F0, 16'h0FF0, 4'd0);
        repeat (5) tick();
        out_ready_v[0] = 1'b1;
        issue(0, 3'd3, 16'hAAAA, 16'hFFFF, 4'd0);
        drain();

        // Reset on BUSY cycle 8 aborts the multiply
        issue(0, 3'd7, 16'h1234, 16'h0F0F, 4'd0);
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        issue(0, 3'd2, 16'h0000, 16'h0, 4'd0);
        drain();

        random_ops(0, 40);

        // WIDTH=8 directed cases
        issue(1, 3'd0, 16'h00FF, 16'h0001, 4'd0);
        issue(1, 3'd0, 16'h008F, 16'h0025, 4'd0);
        issue(1, 3'd7, 16'd20, 16'd13, 4'd0);
        issue(1, 3'd7, 16'h0000, 16'h00FF, 4'd0);
        issue(1, 3'd5, 16'h008F, 16'h0, 4'd3);
        drain();

        random_ops(1, 40);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
